fu_dispatch_router: RTL

- Front end of the functional-unit issue queues: the transmitter side of the per-FU `inst_valid`/`queue_ready` instruction handshake.
- Accepts one renamed instruction per cycle from rename, buffers it in a single holding register, and steers it to the FU queue named by `in_fu_sel`.
- Keeps a PRN busy scoreboard so every source operand is sent with a correct `prn_input_ready` flag.
- Snoops the `set_prn_ready`/`set_prn` writeback broadcast to wake up both the scoreboard and the held instruction.

---
 rtl/fu_dispatch_router_if.sv | 58 +++++
 rtl/fu_dispatch_router.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fu_dispatch_router_if.sv
// Instruction-dispatch bus between rename, the dispatch router and the FU issue queues.
// Groups the rename-side offer, the per-FU instruction bus and the writeback snoop.
interface fu_dispatch_router_if #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4,
  parameter int FU_SEL_BITS  = $clog2(FU_COUNT)
);
  // Handshake: a transfer happens on a clk edge where valid and ready are both 1.
  // valid never depends on ready; while valid is up without ready the payload is held stable.
  logic                                   in_valid;
  logic                                   in_ready;
  logic [INST_ID_BITS-1:0]                in_inst_id;
  logic [31:0]                            in_raw_instr;
  logic [63:0]                            in_instr_pc;
  logic [FU_SEL_BITS-1:0]                 in_fu_sel;
  logic [MAX_OPERANDS-1:0]                in_prn_input_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_prn_input;
  logic [MAX_OPERANDS-1:0]                in_prn_output_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_prn_output;

  logic [FU_COUNT-1:0]                    inst_valid;
  logic [FU_COUNT-1:0]                    queue_ready;
  logic [INST_ID_BITS-1:0]                inst_id;
  logic [31:0]                            raw_instr;
  logic [63:0]                            instr_pc;
  logic [MAX_OPERANDS-1:0]                prn_input_valid;
  logic [MAX_OPERANDS-1:0]                prn_input_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_input;
  logic [MAX_OPERANDS-1:0]                prn_output_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_output;

  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               set_prn_ready;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn;

  logic                                   err_bad_fu;

  // Router view.
  modport slave (
    input  in_valid, in_inst_id, in_raw_instr, in_instr_pc, in_fu_sel,
           in_prn_input_valid, in_prn_input, in_prn_output_valid, in_prn_output,
           queue_ready, set_prn_ready, set_prn,
    output in_ready, inst_valid, inst_id, raw_instr, instr_pc,
           prn_input_valid, prn_input_ready, prn_input, prn_output_valid, prn_output,
           err_bad_fu
  );

  // Environment view: rename, FU queues and writeback together.
  modport master (
    output in_valid, in_inst_id, in_raw_instr, in_instr_pc, in_fu_sel,
           in_prn_input_valid, in_prn_input, in_prn_output_valid, in_prn_output,
           queue_ready, set_prn_ready, set_prn,
    input  in_ready, inst_valid, inst_id, raw_instr, instr_pc,
           prn_input_valid, prn_input_ready, prn_input, prn_output_valid, prn_output,
           err_bad_fu
  );
endinterface

// File: rtl/fu_dispatch_router.sv
// Dispatch router: single holding register steering renamed instructions to FU issue
// queues, with a PRN busy scoreboard supplying per-source ready flags.
module fu_dispatch_router #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4,
  parameter int FU_SEL_BITS  = $clog2(FU_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  fu_dispatch_router_if.slave  bus
);

  localparam int          PRN_COUNT = 2 ** PRN_BITS;
  localparam logic [31:0] FU_LIMIT  = 32'(FU_COUNT);

  logic                                  hold_valid;
  logic [FU_SEL_BITS-1:0]                hold_fu;
  logic [INST_ID_BITS-1:0]               hold_inst_id;
  logic [31:0]                           hold_raw_instr;
  logic [63:0]                           hold_instr_pc;
  logic [MAX_OPERANDS-1:0]               hold_src_valid;
  logic [MAX_OPERANDS-1:0]               hold_src_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] hold_src;
  logic [MAX_OPERANDS-1:0]               hold_dst_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] hold_dst;
  logic [PRN_COUNT-1:0]                  busy;
  logic                                  err_q;

  logic [PRN_COUNT-1:0]                  wake;
  logic [PRN_COUNT-1:0]                  set_vec;
  logic [PRN_COUNT-1:0]                  busy_next;
  logic [FU_COUNT-1:0]                   inst_valid_c;
  logic [MAX_OPERANDS-1:0]               cap_ready;
  logic [MAX_OPERANDS-1:0]               held_ready;
  logic                                  fire;
  logic                                  in_ready_c;
  logic                                  accept;
  logic                                  bad_sel;
  logic                                  load;

  // Any writeback slot of any FU may broadcast any PRN; duplicates just OR together.
  always_comb begin
    wake = '0;
    for (int f = 0; f < FU_COUNT; f++) begin
      for (int o = 0; o < MAX_OPERANDS; o++) begin
        if (bus.set_prn_ready[f][o]) wake[bus.set_prn[f][o]] = 1'b1;
      end
    end
  end

  always_comb begin
    inst_valid_c = '0;
    for (int k = 0; k < FU_COUNT; k++) begin
      inst_valid_c[k] = hold_valid && (hold_fu == FU_SEL_BITS'(k));
    end
  end

  // Only the selected queue's ready can fire; the others are masked by inst_valid_c.
  assign fire       = |(inst_valid_c & bus.queue_ready);
  assign in_ready_c = !hold_valid || fire;
  assign accept     = bus.in_valid && in_ready_c;
  assign bad_sel    = (32'(bus.in_fu_sel) >= FU_LIMIT);
  assign load       = accept && !bad_sel;

  // Capture readiness uses the pre-update busy vector plus same-cycle wakeups.
  always_comb begin
    cap_ready  = '0;
    held_ready = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      cap_ready[i]  = !bus.in_prn_input_valid[i] || !busy[bus.in_prn_input[i]] ||
                      wake[bus.in_prn_input[i]];
      held_ready[i] = hold_src_ready[i] || wake[hold_src[i]];
    end
  end

  // Destination allocation is applied after clearing, so it wins on a same-PRN collision.
  always_comb begin
    set_vec = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (load && bus.in_prn_output_valid[i]) set_vec[bus.in_prn_output[i]] = 1'b1;
    end
    busy_next = (busy & ~wake) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid     <= 1'b0;
      hold_fu        <= '0;
      hold_inst_id   <= '0;
      hold_raw_instr <= '0;
      hold_instr_pc  <= '0;
      hold_src_valid <= '0;
      hold_src_ready <= '0;
      hold_src       <= '0;
      hold_dst_valid <= '0;
      hold_dst       <= '0;
      busy           <= '0;
      err_q          <= 1'b0;
    end else begin
      busy  <= busy_next;
      err_q <= accept && bad_sel;
      if (load) begin
        hold_valid     <= 1'b1;
        hold_fu        <= bus.in_fu_sel;
        hold_inst_id   <= bus.in_inst_id;
        hold_raw_instr <= bus.in_raw_instr;
        hold_instr_pc  <= bus.in_instr_pc;
        hold_src_valid <= bus.in_prn_input_valid;
        hold_src_ready <= cap_ready;
        hold_src       <= bus.in_prn_input;
        hold_dst_valid <= bus.in_prn_output_valid;
        hold_dst       <= bus.in_prn_output;
      end else begin
        if (fire) hold_valid <= 1'b0;
        hold_src_ready <= held_ready;
      end
    end
  end

  assign bus.in_ready         = in_ready_c;
  assign bus.inst_valid       = inst_valid_c;
  assign bus.inst_id          = hold_inst_id;
  assign bus.raw_instr        = hold_raw_instr;
  assign bus.instr_pc         = hold_instr_pc;
  assign bus.prn_input_valid  = hold_src_valid;
  assign bus.prn_input_ready  = hold_src_ready;
  assign bus.prn_input        = hold_src;
  assign bus.prn_output_valid = hold_dst_valid;
  assign bus.prn_output       = hold_dst;
  assign bus.err_bad_fu       = err_q;

endmodule
